serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes DIGIT bits per clock, LSB first, through a chain of full-adder slices.
- Successor to the combinational half/full adder cells in the arithmetic library. Adds WIDTH generality, a subtract mode, signed-overflow detection and a valid/ready handshake on both sides.
- Used where area matters more than latency, for example in datapath accumulators and test fixtures.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0; otherwise the design fails at elaboration via $error.
- STEPS (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- carry  output  1  carry out of MSB (in subtract mode: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst is high:
  - state = IDLE, all registers 0.
  - sum = 0, carry = 0, overflow = 0, out_valid = 0.
  - in_ready = 1, but inputs are ignored until rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready:
    - latch opA = a, opB = sub ? ~b : b, cin = sub, step counter = 0, result register = 0.
    - go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, DIGIT chained full_adder slices add opA[DIGIT-1:0], opB[DIGIT-1:0] and cin.
  - Slice sums shift into the result register from the MSB side (result = {slice_sum, result[WIDTH-1:DIGIT]}).
  - opA and opB shift right by DIGIT; cin <= final slice carry.
  - On the last step (counter == STEPS-1):
    - record carry = carry out of MSB slice;
    - record overflow = carry into MSB slice XOR carry out of MSB slice;
    - go to DONE.
- DONE:
  - out_valid = 1; sum, carry and overflow hold stable.
  - in_ready = 0; in_valid is ignored.
  - On out_valid && out_ready, go to IDLE in the next cycle. out_valid drops and in_ready rises that same cycle.
- Latency:
  - out_valid rises exactly STEPS cycles after the accepting edge.
  - Minimum throughput is one operation per STEPS+2 cycles: accept, STEPS runs, drain.
- No overlap: a new operand is never accepted while RUN or DONE.
- sum, carry and overflow are registered outputs. They hold the last result in IDLE until the next accept clears the result register.
- Width rules: all internal arithmetic is WIDTH bits with no sign extension. Subtract is A + ~B + 1.
- Boundary cases:
  - WIDTH == DIGIT gives STEPS = 1, i.e. single-cycle RUN.
  - out_ready may be high before out_valid; DONE then lasts exactly one cycle.
  - rst asserted mid-RUN or mid-DONE aborts immediately. No partial result is ever presented.

Decomposition:
- Package arith_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;
  - function clog2-based counter width helper.
- Sub-module full_adder (ports Sum, Carry, A, B, Cin), instantiated DIGIT times via generate.

Test Plan:
- Reset mid-RUN: accept a=8'h3C, b=8'h11, assert rst after 3 cycles -> outputs 0, in_ready 1, out_valid never rises for that operation.
- Add wrap (WIDTH=8, DIGIT=1): a=8'hFF, b=8'h01, sub=0 -> out_valid exactly 8 cycles after accept, sum=8'h00, carry=1, overflow=0.
- Signed overflow: a=8'h7F, b=8'h01 add -> sum=8'h80, carry=0, overflow=1; a=8'h80, b=8'h01 sub -> sum=8'h7F, carry=1, overflow=1.
- Borrow: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, carry=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/carry/overflow stable, in_ready=0, new operands not accepted; result retires on the first out_ready=1 cycle.
- Exhaustive WIDTH=4, DIGIT=2: all 512 {a,b,sub} combinations with random out_ready -> every result matches the {carry,sum} = a ± b model plus the overflow rule; latency = 2 cycles each.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the serial adder family.
package arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;

    // Width of a counter that must hold 0 .. steps-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder slice; chained by serial_adder to form one digit.
module full_adder (
    output logic Sum,
    output logic Carry,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with
// valid/ready handshakes on operand and result sides.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    serial_state_t    state, state_nxt;
    logic [WIDTH-1:0] opa, opb, res, res_shift;
    logic             cin;
    logic [CW-1:0]    cnt;
    logic             carry_r, ovf_r;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    logic             accept, last;

    // Carry chain through DIGIT slices; c[0] is the carry held from the previous digit.
    assign c[0] = cin;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_slice
            full_adder u_fa (
                .Sum   (s[i]),
                .Carry (c[i+1]),
                .A     (opa[i]),
                .B     (opb[i]),
                .Cin   (c[i])
            );
        end
    endgenerate

    // New digit enters at the MSB side so the LSB digit ends up at bit 0.
    generate
        if (STEPS == 1) begin : g_one_step
            assign res_shift = s;
        end else begin : g_multi_step
            assign res_shift = {s, res[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign accept = in_valid && (state == IDLE);
    assign last   = (cnt == CW'(STEPS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, digit counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa     <= '0;
            opb     <= '0;
            cin     <= 1'b0;
            cnt     <= '0;
            res     <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            // Subtract as A + ~B + 1: invert B here, inject the +1 as initial carry.
            opa     <= a;
            opb     <= sub ? ~b : b;
            cin     <= sub;
            cnt     <= '0;
            res     <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == RUN) begin
            res <= res_shift;
            opa <= opa >> DIGIT;
            opb <= opb >> DIGIT;
            cin <= c[DIGIT];
            cnt <= cnt + CW'(1);
            if (last) begin
                carry_r <= c[DIGIT];
                ovf_r   <= c[DIGIT-1] ^ c[DIGIT];
            end
        end
    end

    assign sum      = res;
    assign carry    = carry_r;
    assign overflow = ovf_r;

endmodule
